// File: rtl/sdram_phase_sweep_pkg.sv
//------------------------------------------------------------------------------
// Module   : sdram_phase_sweep_pkg
// Brief    : Shared types and helpers for the SDRAM clock-phase calibrator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sdram_phase_sweep_pkg;

    // Index datapath is sized for the largest supported rotation (256 steps).
    localparam int PHASE_STEPS_MAX = 256;
    localparam int PHASE_W         = $clog2(PHASE_STEPS_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        DWELL  = 3'd2,
        EVAL   = 3'd3,
        STEP   = 3'd4,
        CENTER = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        STP_IDLE  = 2'd0,
        STP_SETUP = 2'd1,
        STP_HIGH  = 2'd2,
        STP_LOW   = 2'd3
    } stp_state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] start;
        logic [PHASE_W:0]   len;
    } run_t;

    function automatic logic [PHASE_W-1:0] wrap_idx(input logic [PHASE_W-1:0] idx,
                                                    input int                 steps);
        return idx & PHASE_W'(steps - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_phase_sweep_pll_phase_stepper.sv
//------------------------------------------------------------------------------
// Module   : pll_phase_stepper
// Brief    : Generates one ECP5 PLL phasestep pulse per request, with phasedir
//            set up a cycle ahead; acks on the falling edge of phasestep.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_phase_stepper
    import sdram_phase_sweep_pkg::*;
#(
    parameter int PULSE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic dir,
    output logic phasedir,
    output logic phasestep,
    output logic ack,
    output logic idle
);

    localparam logic [15:0] CNT_LAST = 16'(PULSE_W - 1);

    stp_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic        ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step_d  = step_q;
        ack_d   = 1'b0;
        case (state_q)
            STP_IDLE: begin
                if (req) begin
                    dir_d   = dir;
                    state_d = STP_SETUP;
                end
            end
            STP_SETUP: begin
                step_d  = 1'b1;
                cnt_d   = '0;
                state_d = STP_HIGH;
            end
            STP_HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    step_d  = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = STP_LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STP_LOW: begin
                // phasedir is left untouched so it stays valid past the fall.
                if (cnt_q == CNT_LAST) begin
                    state_d = STP_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = STP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STP_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ack_q   <= ack_d;
        end
    end

    assign phasedir  = dir_q;
    assign phasestep = step_q;
    assign ack       = ack_q;
    assign idle      = (state_q == STP_IDLE);

endmodule

`default_nettype wire

// File: rtl/sdram_phase_sweep.sv
//------------------------------------------------------------------------------
// Module   : sdram_phase_sweep
// Brief    : Sweeps the PLL phase over one rotation, scores each step with
//            mem_tester and parks the clock at the centre of the widest
//            circular passing window. Optional result log: SWEEP_LOG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_phase_sweep
    import sdram_phase_sweep_pkg::*;
#(
    parameter int PHASE_STEPS   = 64,
    parameter int DWELL_CYCLES  = 2**24,
    parameter int SETTLE_CYCLES = 1024,
    parameter int PULSE_W       = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             manual_inc,
    input  logic             manual_dec,
    input  logic [CNT_W-1:0] passcount,
    input  logic [CNT_W-1:0] failcount,
    output logic             tester_rst_n,
    output logic             phasedir,
    output logic             phasestep,
    output logic             phaseloadreg,
    output logic [7:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             sweep_err,
    output logic [7:0]       best_phase,
    output logic [8:0]       best_len,
    input  logic [7:0]       log_addr,
    output logic [CNT_W-1:0] log_data
);

    localparam logic [7:0]  IDX_MASK    = 8'(PHASE_STEPS - 1);
    localparam logic [8:0]  N_LEN       = 9'(PHASE_STEPS);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  phase_q, phase_d;
    logic        tester_rst_n_q, tester_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sweep_err_q, sweep_err_d;
    logic [7:0]  best_phase_q, best_phase_d;
    logic [8:0]  best_len_q, best_len_d;
    logic        req_q, req_d;
    logic        req_dir_q, req_dir_d;
    run_t        cur_q, cur_d;
    run_t        best_q, best_d;
    logic [8:0]  lead_len_q, lead_len_d;
    logic        lead_open_q, lead_open_d;
    logic [8:0]  center_cnt_q, center_cnt_d;

    run_t        cur_n, best_n, win;
    logic [8:0]  lead_n;
    logic        pass_now;
    logic        step_free;
    logic        stp_ack;
    logic        stp_idle;

    pll_phase_stepper #(
        .PULSE_W (PULSE_W)
    ) u_stepper (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_q),
        .dir       (req_dir_q),
        .phasedir  (phasedir),
        .phasestep (phasestep),
        .ack       (stp_ack),
        .idle      (stp_idle)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        tester_rst_n_d = tester_rst_n_q;
        sweep_err_d    = sweep_err_q;
        best_phase_d   = best_phase_q;
        best_len_d     = best_len_q;
        req_d          = 1'b0;
        req_dir_d      = req_dir_q;
        cur_d          = cur_q;
        best_d         = best_q;
        lead_len_d     = lead_len_q;
        lead_open_d    = lead_open_q;
        center_cnt_d   = center_cnt_q;
        cur_n          = cur_q;
        best_n         = best_q;
        lead_n         = lead_len_q;
        win            = best_q;
        // req_q covers the cycle before the stepper reports busy.
        step_free      = stp_idle && !req_q;
        pass_now       = (failcount == '0) && (passcount != '0);

        if (stp_ack) begin
            phase_d = req_dir_q ? wrap_idx(phase_q - 8'd1, PHASE_STEPS)
                                : wrap_idx(phase_q + 8'd1, PHASE_STEPS);
        end

        case (state_q)
            IDLE, DONE: begin
                // A manual step in flight blocks start so the index stays coherent.
                if (start && step_free) begin
                    state_d        = SETTLE;
                    sweep_err_d    = 1'b0;
                    cur_d          = '0;
                    best_d         = '0;
                    lead_len_d     = '0;
                    lead_open_d    = 1'b1;
                    phase_d        = '0;
                    cnt_d          = '0;
                    tester_rst_n_d = 1'b0;
                end else if (step_free && (manual_inc ^ manual_dec)) begin
                    req_d     = 1'b1;
                    req_dir_d = manual_dec;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d          = '0;
                    tester_rst_n_d = 1'b1;
                    state_d        = DWELL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            EVAL: begin
                if (pass_now) begin
                    cur_n.start = (cur_q.len == '0) ? phase_q : cur_q.start;
                    cur_n.len   = cur_q.len + 9'd1;
                    if (lead_open_q) begin
                        lead_n = lead_len_q + 9'd1;
                    end
                    if (cur_n.len > best_q.len) begin
                        best_n = cur_n;
                    end
                end else begin
                    cur_n       = '0;
                    lead_open_d = 1'b0;
                end
                cur_d      = cur_n;
                best_d     = best_n;
                lead_len_d = lead_n;

                if (phase_q == IDX_MASK) begin
                    state_d     = CENTER;
                    sweep_err_d = 1'b0;
                    if (lead_n == N_LEN) begin
                        best_len_d   = N_LEN;
                        best_phase_d = 8'(PHASE_STEPS / 2);
                    end else if (best_n.len == '0) begin
                        sweep_err_d  = 1'b1;
                        best_len_d   = '0;
                        best_phase_d = '0;
                    end else begin
                        // The trailing run continues into the leading run across index 0.
                        win = best_n;
                        if (lead_n != '0 && cur_n.len != '0 &&
                            (lead_n + cur_n.len) > best_n.len) begin
                            win.start = cur_n.start;
                            win.len   = lead_n + cur_n.len;
                        end
                        best_len_d   = win.len;
                        best_phase_d = wrap_idx(win.start + win.len[PHASE_W:1], PHASE_STEPS);
                    end
                    center_cnt_d = {1'b0, best_phase_d} + 9'd1;
                end else begin
                    state_d   = STEP;
                    req_d     = 1'b1;
                    req_dir_d = 1'b0;
                end
            end
            STEP: begin
                if (step_free) begin
                    state_d        = SETTLE;
                    cnt_d          = '0;
                    tester_rst_n_d = 1'b0;
                end
            end
            CENTER: begin
                if (step_free) begin
                    if (center_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        req_d        = 1'b1;
                        req_dir_d    = 1'b0;
                        center_cnt_d = center_cnt_q - 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = !((state_d == IDLE) || (state_d == DONE));
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            phase_q        <= '0;
            tester_rst_n_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sweep_err_q    <= 1'b0;
            best_phase_q   <= '0;
            best_len_q     <= '0;
            req_q          <= 1'b0;
            req_dir_q      <= 1'b0;
            cur_q          <= '0;
            best_q         <= '0;
            lead_len_q     <= '0;
            lead_open_q    <= 1'b0;
            center_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            tester_rst_n_q <= tester_rst_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            sweep_err_q    <= sweep_err_d;
            best_phase_q   <= best_phase_d;
            best_len_q     <= best_len_d;
            req_q          <= req_d;
            req_dir_q      <= req_dir_d;
            cur_q          <= cur_d;
            best_q         <= best_d;
            lead_len_q     <= lead_len_d;
            lead_open_q    <= lead_open_d;
            center_cnt_q   <= center_cnt_d;
        end
    end

`ifdef SWEEP_LOG_EN
    localparam int LOG_AW = $clog2(PHASE_STEPS);

    logic [CNT_W-1:0] log_mem [PHASE_STEPS];
    logic [CNT_W-1:0] log_data_q, log_data_d;

    always_ff @(posedge clk) begin
        if (state_q == EVAL) begin
            log_mem[phase_q[LOG_AW-1:0]] <= (passcount == '0) ? '1 : failcount;
        end
    end

    always_comb begin
        log_data_d = '0;
        if (32'(log_addr) < 32'(PHASE_STEPS)) begin
            log_data_d = log_mem[log_addr[LOG_AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_data_q <= '0;
        end else begin
            log_data_q <= log_data_d;
        end
    end

    assign log_data = log_data_q;
`else
    logic unused_log_addr;
    assign unused_log_addr = ^log_addr;
    assign log_data        = '0;
`endif

    assign tester_rst_n = tester_rst_n_q;
    assign phaseloadreg = 1'b0;
    assign phase        = phase_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sweep_err    = sweep_err_q;
    assign best_phase   = best_phase_q;
    assign best_len     = best_len_q;

endmodule

`default_nettype wire
